// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - dot-product sequencer driving a signed 8x8->16 MAC unit
module mac_dot_seq #(
    parameter int LEN_W = 8,
    parameter int LAT   = 3,
    parameter int WD    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic signed [7:0]       data_a,
    input  logic signed [7:0]       data_b,
    output logic                    mac_clear,
    output logic                    mac_valid_in,
    output logic signed [7:0]       mac_a,
    output logic signed [7:0]       mac_b,
    input  logic                    mac_valid_out,
    input  logic signed [15:0]      mac_f,
    input  logic                    mac_overflow,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [15:0]      res_data,
    output logic                    res_overflow,
    output logic                    res_err,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // The drain watchdog counts DRAIN cycles; it expires on the last one of LAT+WD.
    localparam int              WD_LIMIT = LAT + WD;
    localparam int              WD_W     = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WD_LIMIT - 1);

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        iss_q, iss_d;
    logic [LEN_W-1:0]        rcv_q, rcv_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    data_ready_q, data_ready_d;
    logic                    mac_clear_q, mac_clear_d;
    logic                    mac_valid_in_q, mac_valid_in_d;
    logic signed [7:0]       mac_a_q, mac_a_d;
    logic signed [7:0]       mac_b_q, mac_b_d;
    logic signed [15:0]      res_data_q, res_data_d;
    logic                    res_ovf_q, res_ovf_d;
    logic                    res_err_q, res_err_d;

    logic                    cmd_hs;
    logic                    data_hs;
    logic [LEN_W-1:0]        iss_inc;
    logic [LEN_W-1:0]        rcv_inc;

    assign cmd_hs  = cmd_ready_q && cmd_valid;
    assign data_hs = data_ready_q && data_valid;
    assign iss_inc = iss_q + 1'b1;
    assign rcv_inc = rcv_q + 1'b1;

    // Next-state, counters and registered output values for the job sequence.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        iss_d          = iss_q;
        rcv_d          = rcv_q;
        wd_d           = wd_q;
        mac_valid_in_d = 1'b0;
        mac_a_d        = '0;
        mac_b_d        = '0;
        res_data_d     = res_data_q;
        res_ovf_d      = res_ovf_q;
        res_err_d      = res_err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    if (cmd_len != '0) begin
                        len_d   = cmd_len;
                        iss_d   = '0;
                        rcv_d   = '0;
                        state_d = S_CLEAR;
                    end else begin
                        res_data_d = '0;
                        res_ovf_d  = 1'b0;
                        res_err_d  = 1'b0;
                        state_d    = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (mac_valid_out) begin
                    rcv_d = rcv_inc;
                end
                if (data_hs) begin
                    mac_valid_in_d = 1'b1;
                    mac_a_d        = data_a;
                    mac_b_d        = data_b;
                    iss_d          = iss_inc;
                    if (iss_inc == len_q) begin
                        wd_d    = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (mac_valid_out) begin
                    rcv_d = rcv_inc;
                end
                if (mac_valid_out && (rcv_inc == len_q)) begin
                    res_data_d = mac_f;
                    res_ovf_d  = mac_overflow;
                    res_err_d  = 1'b0;
                    state_d    = S_DONE;
                end else if (wd_q == WD_LAST) begin
                    res_data_d = mac_f;
                    res_ovf_d  = mac_overflow;
                    res_err_d  = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d  = (state_d == S_IDLE);
        data_ready_d = (state_d == S_STREAM);
        mac_clear_d  = (state_d == S_CLEAR);
    end

    // State and output registers; reset holds the MAC cleared and all handshakes idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            iss_q          <= '0;
            rcv_q          <= '0;
            wd_q           <= '0;
            cmd_ready_q    <= 1'b0;
            data_ready_q   <= 1'b0;
            mac_clear_q    <= 1'b1;
            mac_valid_in_q <= 1'b0;
            mac_a_q        <= '0;
            mac_b_q        <= '0;
            res_data_q     <= '0;
            res_ovf_q      <= 1'b0;
            res_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            iss_q          <= iss_d;
            rcv_q          <= rcv_d;
            wd_q           <= wd_d;
            cmd_ready_q    <= cmd_ready_d;
            data_ready_q   <= data_ready_d;
            mac_clear_q    <= mac_clear_d;
            mac_valid_in_q <= mac_valid_in_d;
            mac_a_q        <= mac_a_d;
            mac_b_q        <= mac_b_d;
            res_data_q     <= res_data_d;
            res_ovf_q      <= res_ovf_d;
            res_err_q      <= res_err_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign data_ready   = data_ready_q;
    assign mac_clear    = mac_clear_q;
    assign mac_valid_in = mac_valid_in_q;
    assign mac_a        = mac_a_q;
    assign mac_b        = mac_b_q;
    assign res_valid    = (state_q == S_DONE);
    assign res_data     = res_data_q;
    assign res_overflow = res_ovf_q;
    assign res_err      = res_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb/tb_mac_dot_seq.sv - self-checking bench for mac_dot_seq with a MAC model and job-level reference
module tb_mac_dot_seq;

    localparam int LEN_W = 8;
    localparam int LAT   = 3;
    localparam int WD    = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [LEN_W-1:0]    cmd_len = '0;
    logic                data_valid = 1'b0;
    logic                data_ready;
    logic signed [7:0]   data_a = '0;
    logic signed [7:0]   data_b = '0;
    logic                mac_clear;
    logic                mac_valid_in;
    logic signed [7:0]   mac_a;
    logic signed [7:0]   mac_b;
    logic                mac_valid_out;
    logic signed [15:0]  mac_f;
    logic                mac_overflow;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic signed [15:0]  res_data;
    logic                res_overflow;
    logic                res_err;
    logic                busy;

    int checks = 0;
    int failures = 0;

    mac_dot_seq #(.LEN_W(LEN_W), .LAT(LAT), .WD(WD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_a(data_a), .data_b(data_b),
        .mac_clear(mac_clear), .mac_valid_in(mac_valid_in), .mac_a(mac_a), .mac_b(mac_b),
        .mac_valid_out(mac_valid_out), .mac_f(mac_f), .mac_overflow(mac_overflow),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_overflow(res_overflow), .res_err(res_err), .busy(busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // MAC unit model: async clear, wrapping accumulate, sticky overflow, strobe LAT edges after sampling.
    logic [LAT:0]       mac_pipe;
    logic signed [15:0] mac_acc;
    logic               mac_ovf;
    bit                 suppress = 1'b0;
    int                 mac_sum;
    assign mac_sum       = int'(mac_acc) + int'(mac_a) * int'(mac_b);
    assign mac_f         = mac_acc;
    assign mac_overflow  = mac_ovf;
    assign mac_valid_out = mac_pipe[LAT] && !suppress;
    always @(posedge clk or posedge mac_clear) begin
        if (mac_clear) begin
            mac_pipe <= '0;
            mac_acc  <= '0;
            mac_ovf  <= 1'b0;
        end else begin
            mac_pipe <= {mac_pipe[LAT-1:0], mac_valid_in};
            if (mac_valid_in) begin
                mac_acc <= 16'(mac_sum);
                if (mac_sum > 32767 || mac_sum < -32768) mac_ovf <= 1'b1;
            end
        end
    end

    // Job-level reference: expected sum and overflow from exact integer arithmetic, result timing from latency rules.
    int                 cyc = 0;
    int                 cap_cyc = -1;
    int                 job_len = 0;
    int                 n_hs = 0;
    longint             m_sum = 0;
    bit                 m_ovf = 1'b0;
    bit                 m_sup = 1'b0;
    bit                 exp_vin = 1'b0;
    bit                 exp_clear = 1'b1;
    bit                 exp_rv = 1'b0;
    bit                 exp_ovf = 1'b0;
    bit                 exp_err = 1'b0;
    int                 exp_a = 0;
    int                 exp_b = 0;
    logic signed [15:0] exp_data = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_vin   = 1'b0;
            exp_a     = 0;
            exp_b     = 0;
            exp_clear = 1'b1;
            exp_rv    = 1'b0;
            cap_cyc   = -1;
        end else begin
            cyc++;
            exp_clear = 1'b0;
            exp_vin   = 1'b0;
            exp_a     = 0;
            exp_b     = 0;
            if (res_valid && res_ready) exp_rv = 1'b0;
            if (cmd_valid && cmd_ready) begin
                if (cmd_len == '0) begin
                    exp_rv   = 1'b1;
                    exp_data = '0;
                    exp_ovf  = 1'b0;
                    exp_err  = 1'b0;
                end else begin
                    exp_clear = 1'b1;
                    job_len   = int'(cmd_len);
                    n_hs      = 0;
                    m_sum     = 0;
                    m_ovf     = 1'b0;
                end
            end
            if (data_valid && data_ready) begin
                exp_vin = 1'b1;
                exp_a   = int'(data_a);
                exp_b   = int'(data_b);
                m_sum  += longint'(data_a) * longint'(data_b);
                if (m_sum > 32767 || m_sum < -32768) m_ovf = 1'b1;
                n_hs++;
                if (n_hs == job_len) begin
                    cap_cyc = cyc + LAT + (suppress ? WD : 2);
                    m_sup   = suppress;
                end
            end
            if (cyc == cap_cyc) begin
                exp_rv   = 1'b1;
                exp_data = 16'(m_sum);
                exp_ovf  = m_ovf;
                exp_err  = m_sup;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the reference, away from the active edge.
    int clr_hi = 0;
    int vin_hi = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mac_clear) clr_hi++;
            if (mac_valid_in) vin_hi++;
            chk("mac_clear", mac_clear, exp_clear);
            chk("mac_valid_in", mac_valid_in, exp_vin);
            chk("mac_a", mac_a, exp_a);
            chk("mac_b", mac_b, exp_b);
            chk("res_valid", res_valid, exp_rv);
            if (exp_rv) begin
                chk("res_data", res_data, exp_data);
                chk("res_overflow", res_overflow, exp_ovf);
                chk("res_err", res_err, exp_err);
                chk("cmd_ready_in_done", cmd_ready, 0);
            end
        end
    end

    int qa[$];
    int qb[$];
    int qg[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input int a, input int b, output int hs_cyc);
        int n;
        data_valid = 1'b1;
        data_a     = 8'(a);
        data_b     = 8'(b);
        n = 0;
        while (!data_ready && n < 100) begin
            tick();
            n++;
        end
        if (!data_ready) chk("data_ready_timeout", 0, 1);
        tick();
        hs_cyc     = cyc;
        data_valid = 1'b0;
        data_a     = '0;
        data_b     = '0;
    endtask

    task automatic start_cmd(input int len, output int acc_cyc);
        int n;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
        tick();
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic run_job(input int len, input int hold, input bit lit, input longint e_data,
                           input bit e_ovf, input bit e_err,
                           output int acc_cyc, output int fh_cyc, output int rv_cyc);
        int n;
        int hs;
        start_cmd(len, acc_cyc);
        fh_cyc = acc_cyc;
        for (int i = 0; i < len; i++) begin
            repeat (qg[i]) tick();
            send_pair(qa[i], qb[i], hs);
            if (i == 0) fh_cyc = hs;
        end
        if (lit && len > 0) chk("data_ready_drop", data_ready, 0);
        n = 0;
        while (!res_valid && n < 100) begin
            tick();
            n++;
        end
        if (!res_valid) chk("res_valid_timeout", 0, 1);
        rv_cyc = cyc;
        if (lit) begin
            chk("lit_res_data", res_data, e_data);
            chk("lit_res_overflow", res_overflow, e_ovf);
            chk("lit_res_err", res_err, e_err);
        end
        for (int h = 0; h < hold; h++) begin
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_busy", busy, 1);
            if (lit) chk("bp_res_data", res_data, e_data);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // Directed cases from the job rules, then randomized jobs checked by the reference.
    initial begin
        int ac, fh, rv, hs, len, c0, v0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_mac_clear", mac_clear, 1);
        chk("rst_mac_valid_in", mac_valid_in, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("release_mac_clear", mac_clear, 0);
        chk("release_cmd_ready", cmd_ready, 1);

        qa = {2, 3}; qb = {2, -3}; qg = {0, 0};
        run_job(2, 0, 1'b1, -5, 1'b0, 1'b0, ac, fh, rv);
        chk("t1_latency", rv - fh, 6);

        qa = {125, 125, 125}; qb = {100, 100, 100}; qg = {0, 0, 0};
        run_job(3, 0, 1'b1, -28036, 1'b1, 1'b0, ac, fh, rv);

        qa = {50, 100}; qb = {15, 2}; qg = {0, 2};
        run_job(2, 0, 1'b1, 950, 1'b0, 1'b0, ac, fh, rv);

        c0 = clr_hi; v0 = vin_hi;
        qa = {}; qb = {}; qg = {};
        run_job(0, 0, 1'b1, 0, 1'b0, 1'b0, ac, fh, rv);
        chk("t4_latency", rv - ac, 0);
        chk("t4_no_clear", clr_hi - c0, 0);
        chk("t4_no_valid_in", vin_hi - v0, 0);

        qa = {125, 125, 125}; qb = {100, 100, 100}; qg = {0, 0, 0};
        run_job(3, 5, 1'b1, -28036, 1'b1, 1'b0, ac, fh, rv);
        qa = {100}; qb = {2}; qg = {0};
        run_job(1, 0, 1'b1, 200, 1'b0, 1'b0, ac, fh, rv);

        start_cmd(4, ac);
        send_pair(1, 1, hs);
        send_pair(2, 2, hs);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_mac_clear", mac_clear, 1);
        chk("midrst_data_ready", data_ready, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        chk("midrst_mac_valid_in", mac_valid_in, 0);
        chk("midrst_res_valid", res_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        qa = {2}; qb = {2}; qg = {0};
        run_job(1, 0, 1'b1, 4, 1'b0, 1'b0, ac, fh, rv);

        suppress = 1'b1;
        qa = {3}; qb = {4}; qg = {0};
        run_job(1, 0, 1'b1, 12, 1'b0, 1'b1, ac, fh, rv);
        chk("wd_latency", rv - fh, LAT + WD);
        suppress = 1'b0;

        for (int j = 0; j < 40; j++) begin
            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            qa = {}; qb = {}; qg = {};
            for (int i = 0; i < len; i++) begin
                qa.push_back(int'($urandom_range(0, 255)) - 128);
                qb.push_back(int'($urandom_range(0, 255)) - 128);
                qg.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            suppress = (len > 0) && ($urandom_range(0, 7) == 0);
            run_job(len, int'($urandom_range(0, 3)), 1'b0, 0, 1'b0, 1'b0, ac, fh, rv);
            suppress = 1'b0;
        end

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if a bounded wait ever fails to bound the run.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Sequencer that drives one signed 8x8→16 multiply-accumulate unit to compute dot products of length N. It accepts a job command, pulses the MAC's clear, streams N operand pairs into it, and counts MAC output strobes. It then returns the final accumulator and the MAC's sticky overflow flag through a result handshake. It sits between an operand source (FIFO or memory reader) and the MAC instance.

## Interface
- LEN_W, 8, width of job length field (max N = 2^LEN_W-1)
- LAT, 3, MAC latency in cycles from sampling valid_in to asserting valid_out
- WD, 4, drain watchdog limit in cycles
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces all state to reset values immediately
- cmd_valid / cmd_ready  in/out  1/1  job command handshake
- cmd_len  in  LEN_W  number of operand pairs N
- data_valid / data_ready  in/out  1/1  operand handshake
- data_a, data_b  in  8 each  signed operands
- mac_clear  out  1  active-high clear to MAC (its async reset), registered
- mac_valid_in  out  1  registered, to MAC valid_in
- mac_a, mac_b  out  8 each  registered signed operands to MAC
- mac_valid_out  in  1  MAC output strobe
- mac_f  in  16  MAC accumulator, signed
- mac_overflow  in  1  MAC sticky overflow
- res_valid / res_ready  out/in  1/1  result handshake
- res_data  out  16  signed dot product (two's-complement wrap)
- res_overflow  out  1  mac_overflow at capture
- res_err  out  1  watchdog expired before N strobes were received
- busy  out  1  state != IDLE

## Operation
- Reset values: cmd_ready=0, data_ready=0, mac_clear=1 (MAC held cleared during reset), mac_valid_in=0, mac_a=mac_b=0, res_valid=0, res_data=0, res_overflow=0, res_err=0, busy=0. State is IDLE. mac_clear drops at the first edge after release.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: cmd_ready=1.
  - cmd_valid with cmd_len≠0: latch len, zero the issue and receive counters, go CLEAR.
  - cmd_valid with cmd_len=0: res_data=0, res_overflow=0, res_err=0, go DONE. No MAC activity.
- CLEAR: mac_clear=1 for exactly one cycle, then go STREAM.
- STREAM: data_ready=1.
  - On each data handshake: mac_valid_in<=1, mac_a<=data_a, mac_b<=data_b, issue count +1.
  - Cycles without a handshake: mac_valid_in<=0 and operands <=0. Bubbles are allowed.
  - When issue count reaches len: data_ready drops in the same cycle as the last handshake; go DRAIN.
- Receive counter increments on every mac_valid_out in STREAM and DRAIN. mac_valid_out is ignored in IDLE, CLEAR and DONE.
- DRAIN: on the mac_valid_out that brings the receive count to len, capture mac_f and mac_overflow, set res_err=0, go DONE.
- Watchdog: if DRAIN lasts LAT+WD cycles without completion, capture mac_f and mac_overflow, set res_err=1, go DONE.
- DONE: res_valid=1; res_data, res_overflow and res_err are held stable until res_ready. On handshake go IDLE. cmd_ready=0 throughout DONE.
- Results are never merged across jobs: CLEAR empties the MAC before every non-empty job.

## Timing
- Command accepted at edge c: mac_clear is high in cycle (c, c+1]; data_ready is high from edge c+1.
- Operand handshake at edge k: mac_valid_in is high in (k, k+1], the MAC samples at k+1, and mac_valid_out is high after k+1+LAT.
- Last handshake at edge t: result captured at t+LAT+2; res_valid is high from that edge.
- Back-to-back job of N pairs starting at edge t0: res_valid is high at t0+N+LAT+1.
- Minimum one IDLE cycle between jobs.
- Reset asserted mid-job: job is discarded, outputs return to reset values asynchronously, mac_clear=1. No result is produced.

## Test plan
- len=2, pairs (2,2),(3,-3) back-to-back → res_data=-5, res_overflow=0, res_err=0; res_valid 6 edges after the first handshake.
- len=3, pairs (125,100)×3 → res_data=-28036, res_overflow=1.
- len=2, pairs (50,15),(100,2) with a 2-cycle data_valid gap → res_data=950; mac_valid_in low during the gap.
- cmd_len=0 → res_valid one edge later with res_data=0; mac_clear and mac_valid_in never pulse.
- Result backpressure: hold res_ready=0 for 5 cycles → outputs stable and cmd_ready=0. Then run a second job, len=1, (100,2) → res_data=200, res_overflow=0 (no carry-over from the first job).
- Robustness, two cases:
  - Reset low during STREAM, then a new job of (2,2) → res_data=4.
  - MAC model suppresses the final mac_valid_out → res_err=1 after LAT+WD cycles in DRAIN.
